// File: rtl/mem2_load_unit.sv
// MEM2 load stage: serves cached hits from the dcache and runs uncached reads over a request/response channel.
// Define MEM2_LOAD_PERF_EN to build the uncached-load and load-stall performance counters.
module mem2_load_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem1_load_valid,
   input  logic        mem1_uncached,
   input  logic [31:0] mem1_addr,
   input  logic [1:0]  mem1_size,
   input  logic        stall_in,
   input  logic        flush,
   input  logic [31:0] dcache_rdata,
   input  logic        dcache_hit,
   output logic        unc_rd_req,
   output logic [31:0] unc_rd_addr,
   output logic [1:0]  unc_rd_size,
   input  logic        unc_rd_ready,
   input  logic        unc_rd_rvalid,
   input  logic [31:0] unc_rd_rdata,
   output logic [31:0] cache_rdata,
   output logic [31:0] RdAddr,
   output logic        rdata_valid,
   output logic        load_busy,
   output logic [31:0] unc_load_cnt,
   output logic [31:0] load_stall_cnt
);

   typedef enum logic [2:0] {IDLE, UNC_REQ, UNC_WAIT, HOLD, DRAIN} state_t;

   state_t      state_q, state_d;
   logic        valid_q, valid_d;
   logic        unc_q, unc_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] hold_q, hold_d;
   logic        unc_req_q, unc_req_d;
   logic        adv;

   assign adv         = !stall_in && !load_busy;
   assign RdAddr      = addr_q;
   assign unc_rd_size = size_q;
   assign unc_rd_addr = (size_q == 2'd2) ? {addr_q[31:2], 2'b00} : addr_q;
   assign unc_rd_req  = unc_req_q;

   // A flush kills the slot even while stalled, so a held uncached load is never reissued.
   always_comb begin
      valid_d = valid_q;
      unc_d   = unc_q;
      addr_d  = addr_q;
      size_d  = size_q;
      if (adv) begin
         valid_d = mem1_load_valid;
         unc_d   = mem1_uncached;
         addr_d  = mem1_addr;
         size_d  = mem1_size;
      end
      if (flush) begin
         valid_d = 1'b0;
      end
   end

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      rdata_valid = 1'b0;
      cache_rdata = hold_q;
      load_busy   = 1'b0;
      case (state_q)
         IDLE: begin
            if (valid_q && !flush) begin
               if (unc_q) begin
                  load_busy = 1'b1;
                  state_d   = UNC_REQ;
               end else begin
                  rdata_valid = dcache_hit;
                  cache_rdata = dcache_rdata;
                  load_busy   = !dcache_hit;
                  if (dcache_hit && stall_in) begin
                     hold_d  = dcache_rdata;
                     state_d = HOLD;
                  end
               end
            end
         end
         UNC_REQ: begin
            load_busy = 1'b1;
            if (flush) begin
               state_d = unc_rd_ready ? DRAIN : IDLE;
            end else if (unc_rd_ready) begin
               state_d = UNC_WAIT;
            end
         end
         UNC_WAIT: begin
            load_busy = 1'b1;
            if (flush) begin
               state_d = unc_rd_rvalid ? IDLE : DRAIN;
            end else if (unc_rd_rvalid) begin
               hold_d  = unc_rd_rdata;
               state_d = HOLD;
            end
         end
         HOLD: begin
            rdata_valid = 1'b1;
            cache_rdata = hold_q;
            if (!stall_in || flush) begin
               state_d = IDLE;
            end
         end
         DRAIN: begin
            load_busy = 1'b1;
            if (unc_rd_rvalid) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      unc_req_d = (state_d == UNC_REQ);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         valid_q   <= 1'b0;
         unc_q     <= 1'b0;
         addr_q    <= 32'd0;
         size_q    <= 2'd0;
         hold_q    <= 32'd0;
         unc_req_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         valid_q   <= valid_d;
         unc_q     <= unc_d;
         addr_q    <= addr_d;
         size_q    <= size_d;
         hold_q    <= hold_d;
         unc_req_q <= unc_req_d;
      end
   end

`ifdef MEM2_LOAD_PERF_EN
   logic [31:0] unc_cnt_q, unc_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Both counters wrap naturally at 2^32.
   always_comb begin
      unc_cnt_d   = unc_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (unc_rd_req && unc_rd_ready) begin
         unc_cnt_d = unc_cnt_q + 32'd1;
      end
      if (load_busy) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         unc_cnt_q   <= 32'd0;
         stall_cnt_q <= 32'd0;
      end else begin
         unc_cnt_q   <= unc_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign unc_load_cnt   = unc_cnt_q;
   assign load_stall_cnt = stall_cnt_q;
`else
   assign unc_load_cnt   = 32'd0;
   assign load_stall_cnt = 32'd0;
`endif

endmodule

// File: doc/mem2_load_unit.md
MEM2_LOAD_UNIT -- requirements
Module: mem2_load_unit

Interface
REQ-001 SHALL have ports, in this order: clk, input, 1, core clock; all state on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high.
REQ-003 SHALL have port mem1_load_valid, input, 1, MEM1 holds a load for MEM2.
REQ-004 SHALL have port mem1_uncached, input, 1, the MEM1 load is uncached.
REQ-005 SHALL have port mem1_addr, input, 32, load physical address (unaligned low bits kept).
REQ-006 SHALL have port mem1_size, input, 2, load size: 0 byte, 1 half, 2 word (LW/LWL/LWR).
REQ-007 SHALL have port stall_in, input, 1, downstream stall.
REQ-008 SHALL have port flush, input, 1, kill the MEM2 load.
REQ-009 SHALL have ports dcache_rdata, input, 32, and dcache_hit, input, 1: cache word and hit flag, valid while the load is in MEM2.
REQ-010 SHALL have ports unc_rd_req, output, 1; unc_rd_addr, output, 32; unc_rd_size, output, 2; unc_rd_ready, input, 1: uncached request channel.
REQ-011 SHALL have ports unc_rd_rvalid, input, 1, and unc_rd_rdata, input, 32: uncached response channel.
REQ-012 SHALL have ports cache_rdata, output, 32, and RdAddr, output, 32: word and address for the load-data select stage.
REQ-013 SHALL have port rdata_valid, output, 1, cache_rdata is final this cycle.
REQ-014 SHALL have port load_busy, output, 1, MEM2 load not done; stalls MEM1 and upstream.
REQ-015 SHALL have ports unc_load_cnt, output, 32, and load_stall_cnt, output, 32: performance counters.

Function
REQ-016 SHALL define adv = !stall_in && !load_busy; on adv, latch mem1_* into the MEM2 registers (valid, uncached, addr, size), and latch valid as 0 if flush is 1.
REQ-017 SHALL drive RdAddr = latched addr; unc_rd_size = latched size; unc_rd_addr = latched addr, with bits [1:0] forced to 0 when size = 2.
REQ-018 SHALL use FSM states IDLE, UNC_REQ, UNC_WAIT, HOLD, DRAIN.
REQ-019 IDLE, cached valid load: rdata_valid = dcache_hit, cache_rdata = dcache_rdata, load_busy = !dcache_hit; if hit and stall_in, capture dcache_rdata into hold_q and go to HOLD.
REQ-020 IDLE, uncached valid load, no flush: go to UNC_REQ next cycle; load_busy = 1.
REQ-021 UNC_REQ: unc_rd_req = 1 with stable addr/size; on unc_rd_ready go to UNC_WAIT; on flush (with or without ready that cycle) drop to IDLE (with ready: to DRAIN).
REQ-022 UNC_WAIT: on unc_rd_rvalid capture unc_rd_rdata into hold_q and go to HOLD; on flush go to DRAIN (same-cycle rvalid+flush: discard, go to IDLE).
REQ-023 HOLD: rdata_valid = 1, cache_rdata = hold_q, load_busy = 0; leave to IDLE when !stall_in or flush.
REQ-024 DRAIN: load_busy = 1, unc_rd_req = 0, wait for unc_rd_rvalid, discard data, go to IDLE; the newly latched load then proceeds from IDLE.
REQ-025 SHALL keep at most one uncached request outstanding; unc_rd_req SHALL never be 1 outside UNC_REQ.
REQ-026 Invalid MEM2 slot or flush in IDLE: rdata_valid = 0, load_busy = 0.

Reset
REQ-027 On reset, state SHALL be IDLE, MEM2 valid = 0, hold_q = 0, all counters = 0, unc_rd_req = 0, rdata_valid = 0, load_busy = 0; reset mid-transaction SHALL abandon it without DRAIN.

Configuration
REQ-028 With MEM2_LOAD_PERF_EN defined: unc_load_cnt SHALL increment on each UNC_REQ handshake, load_stall_cnt SHALL increment each cycle load_busy = 1, and both SHALL wrap at 2^32.
REQ-029 Without MEM2_LOAD_PERF_EN: both counter ports SHALL be constant 0 and no counter registers SHALL exist.

Verification
REQ-030 Cached LW addr 0x1000, hit = 1, rdata 0xDEADBEEF, stall_in = 0 -> rdata_valid = 1 same cycle, RdAddr = 0x1000, load_busy = 0.
REQ-031 Cached hit, stall_in = 1 for 3 cycles, dcache_rdata changes after cycle 1 -> cache_rdata held at 0x12345678 for all 3 cycles.
REQ-032 Uncached LH addr 0xBFD0_0002, ready after 2 cycles, rvalid 3 cycles later with 0x0000ABCD -> unc_rd_addr = 0xBFD00002, size 1, load_busy = 1 until HOLD, then rdata_valid = 1.
REQ-033 Uncached LWL addr 0xBFD0_0007 -> unc_rd_addr = 0xBFD00004, RdAddr = 0xBFD00007.
REQ-034 Flush in UNC_WAIT, next load uncached -> DRAIN; no new unc_rd_req until stale rvalid; stale data never appears with rdata_valid = 1.
REQ-035 MEM2_LOAD_PERF_EN on, 2 uncached loads, 7 busy cycles -> unc_load_cnt = 2, load_stall_cnt = 7; macro off -> both 0.
